// File: rtl/matching_pkg.sv
// Shared definitions for the order book matcher: FSM states, the count-width
// helper and the empty-book price sentinels.
package matching_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    TRADE = 1'b1
  } state_t;

  // Width needed to hold a resting-order count in the range 0..depth.
  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Price reported by a side with no resting orders: 0 for bids, all-ones for asks.
  function automatic logic [63:0] empty_price(input int w, input bit is_bid);
    return is_bid ? 64'd0 : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/book_side.sv
// One side of the limit order book. Orders are kept in arrival order in a
// compacted array (index 0 is oldest). Supports appending, subtracting a fill
// from one entry, and removing that entry with a one-edge shift-down.
// IS_BID selects a max-price search (bids) or a min-price search (asks).
module book_side
  import matching_pkg::*;
#(
  parameter int PRICE_W = 8,
  parameter int QTY_W   = 8,
  parameter int DEPTH   = 8,
  parameter bit IS_BID  = 1'b1,
  localparam int CW     = count_w(DEPTH),
  localparam int IW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ins_en,
  input  logic [PRICE_W-1:0] ins_price,
  input  logic [QTY_W-1:0]   ins_qty,
  input  logic               sub_en,
  input  logic [IW-1:0]      sub_idx,
  input  logic [QTY_W-1:0]   sub_qty,
  output logic [PRICE_W-1:0] best_price,
  output logic [IW-1:0]      best_idx,
  output logic [QTY_W-1:0]   best_qty,
  output logic [CW-1:0]      count,
  output logic               full
);

  localparam logic [PRICE_W-1:0] SENTINEL = PRICE_W'(empty_price(PRICE_W, IS_BID));

  logic [PRICE_W-1:0] price_reg [DEPTH];
  logic [QTY_W-1:0]   qty_reg   [DEPTH];
  logic [CW-1:0]      count_reg;
  logic               remove;
  logic               best_found;

  // A fill that consumes the whole entry removes it instead of leaving a zero.
  assign remove = (qty_reg[sub_idx] == sub_qty);

  // Storage update: fill/remove during a trade handshake, append otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (sub_en) begin
      if (remove) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          if (IW'(i) >= sub_idx) begin
            price_reg[i] <= price_reg[i+1];
            qty_reg[i]   <= qty_reg[i+1];
          end
        end
        count_reg <= count_reg - 1'b1;
      end else begin
        qty_reg[sub_idx] <= qty_reg[sub_idx] - sub_qty;
      end
    end else if (ins_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == count_reg) begin
          price_reg[i] <= ins_price;
          qty_reg[i]   <= ins_qty;
        end
      end
      count_reg <= count_reg + 1'b1;
    end
  end

  // Best-price search over valid entries; strict compare keeps the oldest on ties.
  always_comb begin
    best_found = 1'b0;
    best_price = SENTINEL;
    best_idx   = '0;
    best_qty   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_reg) begin
        if (!best_found ||
            (IS_BID ? (price_reg[i] > best_price) : (price_reg[i] < best_price))) begin
          best_found = 1'b1;
          best_price = price_reg[i];
          best_idx   = IW'(i);
          best_qty   = qty_reg[i];
        end
      end
    end
  end

  assign count = count_reg;
  assign full  = (count_reg == CW'(DEPTH));

endmodule

// File: rtl/order_book_matcher.sv
// Price-time-priority limit order book matcher. Accepts buy/sell orders via
// valid/ready, and when the book is crossed emits one trade at a time at the
// bid/ask midpoint for the smaller of the two best quantities.
// Optional build macro ORDER_BOOK_STATS_EN adds saturating trade_count/volume.
module order_book_matcher
  import matching_pkg::*;
#(
  parameter int PRICE_W = 8,
  parameter int QTY_W   = 8,
  parameter int DEPTH   = 8,
  localparam int CW     = count_w(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               buy_valid,
  output logic               buy_ready,
  input  logic [PRICE_W-1:0] buy_price,
  input  logic [QTY_W-1:0]   buy_qty,
  input  logic               sell_valid,
  output logic               sell_ready,
  input  logic [PRICE_W-1:0] sell_price,
  input  logic [QTY_W-1:0]   sell_qty,
  output logic               trade_valid,
  input  logic               trade_ready,
  output logic [PRICE_W-1:0] trade_price,
  output logic [QTY_W-1:0]   trade_qty,
  output logic [PRICE_W-1:0] best_bid,
  output logic [PRICE_W-1:0] best_ask,
  output logic [CW-1:0]      bid_count,
  output logic [CW-1:0]      ask_count
`ifdef ORDER_BOOK_STATS_EN
  ,
  output logic [31:0]        trade_count,
  output logic [31:0]        volume
`endif
);

  localparam int IW = $clog2(DEPTH);

  state_t             state_reg;
  logic [IW-1:0]      bid_idx_reg;
  logic [IW-1:0]      ask_idx_reg;
  logic               trade_valid_reg;
  logic [PRICE_W-1:0] trade_price_reg;
  logic [QTY_W-1:0]   trade_qty_reg;

  logic               bid_full;
  logic               ask_full;
  logic [IW-1:0]      best_bid_idx;
  logic [IW-1:0]      best_ask_idx;
  logic [QTY_W-1:0]   best_bid_qty;
  logic [QTY_W-1:0]   best_ask_qty;
  logic               buy_ins;
  logic               sell_ins;
  logic               crossed;
  logic               trade_fire;
  logic [PRICE_W:0]   price_sum;

  assign buy_ready  = (state_reg == IDLE) && !bid_full;
  assign sell_ready = (state_reg == IDLE) && !ask_full;

  // Zero-quantity orders complete the handshake but are never stored.
  assign buy_ins    = buy_valid && buy_ready && (buy_qty != '0);
  assign sell_ins   = sell_valid && sell_ready && (sell_qty != '0);
  assign trade_fire = trade_valid_reg && trade_ready;
  assign crossed    = (bid_count != '0) && (ask_count != '0) && (best_bid >= best_ask);
  assign price_sum  = {1'b0, best_bid} + {1'b0, best_ask};

  book_side #(
    .PRICE_W (PRICE_W),
    .QTY_W   (QTY_W),
    .DEPTH   (DEPTH),
    .IS_BID  (1'b1)
  ) u_bids (
    .clk        (clk),
    .reset      (reset),
    .ins_en     (buy_ins),
    .ins_price  (buy_price),
    .ins_qty    (buy_qty),
    .sub_en     (trade_fire),
    .sub_idx    (bid_idx_reg),
    .sub_qty    (trade_qty_reg),
    .best_price (best_bid),
    .best_idx   (best_bid_idx),
    .best_qty   (best_bid_qty),
    .count      (bid_count),
    .full       (bid_full)
  );

  book_side #(
    .PRICE_W (PRICE_W),
    .QTY_W   (QTY_W),
    .DEPTH   (DEPTH),
    .IS_BID  (1'b0)
  ) u_asks (
    .clk        (clk),
    .reset      (reset),
    .ins_en     (sell_ins),
    .ins_price  (sell_price),
    .ins_qty    (sell_qty),
    .sub_en     (trade_fire),
    .sub_idx    (ask_idx_reg),
    .sub_qty    (trade_qty_reg),
    .best_price (best_ask),
    .best_idx   (best_ask_idx),
    .best_qty   (best_ask_qty),
    .count      (ask_count),
    .full       (ask_full)
  );

  // Matching FSM: latch a crossed pair in IDLE, present it until consumed in TRADE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      bid_idx_reg     <= '0;
      ask_idx_reg     <= '0;
      trade_valid_reg <= 1'b0;
      trade_price_reg <= '0;
      trade_qty_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (crossed) begin
            bid_idx_reg     <= best_bid_idx;
            ask_idx_reg     <= best_ask_idx;
            trade_price_reg <= PRICE_W'(price_sum >> 1);
            trade_qty_reg   <= (best_bid_qty < best_ask_qty) ? best_bid_qty : best_ask_qty;
            trade_valid_reg <= 1'b1;
            state_reg       <= TRADE;
          end
        end
        TRADE: begin
          if (trade_ready) begin
            trade_valid_reg <= 1'b0;
            state_reg       <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign trade_valid = trade_valid_reg;
  assign trade_price = trade_price_reg;
  assign trade_qty   = trade_qty_reg;

`ifdef ORDER_BOOK_STATS_EN
  logic [31:0] trade_count_reg;
  logic [31:0] volume_reg;
  logic [32:0] volume_sum;

  assign volume_sum = {1'b0, volume_reg} + 33'(trade_qty_reg);

  // Saturating trade statistics, bumped on every trade handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      trade_count_reg <= '0;
      volume_reg      <= '0;
    end else if (trade_fire) begin
      if (trade_count_reg != '1) begin
        trade_count_reg <= trade_count_reg + 32'd1;
      end
      volume_reg <= volume_sum[32] ? '1 : volume_sum[31:0];
    end
  end

  assign trade_count = trade_count_reg;
  assign volume      = volume_reg;
`endif

endmodule

// File: tb/tb_order_book_matcher.sv
// Directed self-checking bench for order_book_matcher (default 8/8/8 config).
module tb_order_book_matcher;

  logic       clk = 1'b0;
  logic       reset;
  logic       buy_valid, sell_valid;
  logic       buy_ready, sell_ready;
  logic [7:0] buy_price, sell_price, buy_qty, sell_qty;
  logic       trade_valid, trade_ready;
  logic [7:0] trade_price, trade_qty;
  logic [7:0] best_bid, best_ask;
  logic [3:0] bid_count, ask_count;
`ifdef ORDER_BOOK_STATS_EN
  logic [31:0] trade_count, volume;
`endif

  int checks = 0;
  int errors = 0;

  order_book_matcher #(.PRICE_W(8), .QTY_W(8), .DEPTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .buy_valid   (buy_valid),
    .buy_ready   (buy_ready),
    .buy_price   (buy_price),
    .buy_qty     (buy_qty),
    .sell_valid  (sell_valid),
    .sell_ready  (sell_ready),
    .sell_price  (sell_price),
    .sell_qty    (sell_qty),
    .trade_valid (trade_valid),
    .trade_ready (trade_ready),
    .trade_price (trade_price),
    .trade_qty   (trade_qty),
    .best_bid    (best_bid),
    .best_ask    (best_ask),
    .bid_count   (bid_count),
    .ask_count   (ask_count)
`ifdef ORDER_BOOK_STATS_EN
    ,
    .trade_count (trade_count),
    .volume      (volume)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    buy_valid = 0; sell_valid = 0; trade_ready = 1;
    buy_price = 0; buy_qty = 0; sell_price = 0; sell_qty = 0;
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  task automatic send_buy(input logic [7:0] p, input logic [7:0] q);
    int n = 0;
    buy_valid = 1; buy_price = p; buy_qty = q;
    while (!buy_ready && n < 50) begin tick(); n++; end
    checks++;
    if (!buy_ready) begin errors++; $display("FAIL buy_handshake_timeout ready=%0b required=1", buy_ready); end
    tick();
    buy_valid = 0;
  endtask

  task automatic send_sell(input logic [7:0] p, input logic [7:0] q);
    int n = 0;
    sell_valid = 1; sell_price = p; sell_qty = q;
    while (!sell_ready && n < 50) begin tick(); n++; end
    checks++;
    if (!sell_ready) begin errors++; $display("FAIL sell_handshake_timeout ready=%0b required=1", sell_ready); end
    tick();
    sell_valid = 0;
  endtask

  task automatic wait_trade();
    int n = 0;
    while (!trade_valid && n < 50) begin tick(); n++; end
    checks++;
    if (!trade_valid) begin errors++; $display("FAIL trade_timeout valid=%0b required=1", trade_valid); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (best_bid !== 8'h00) begin errors++; $display("FAIL reset_best_bid got=%0h exp=00", best_bid); end
    checks++; if (best_ask !== 8'hFF) begin errors++; $display("FAIL reset_best_ask got=%0h exp=ff", best_ask); end
    checks++; if (bid_count !== 0 || ask_count !== 0) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", bid_count, ask_count); end
    checks++; if (trade_valid !== 0 || trade_price !== 0 || trade_qty !== 0) begin errors++; $display("FAIL reset_trade got=%0b/%0h/%0h exp=0/0/0", trade_valid, trade_price, trade_qty); end
    checks++; if (buy_ready !== 1 || sell_ready !== 1) begin errors++; $display("FAIL reset_ready got=%0b/%0b exp=1/1", buy_ready, sell_ready); end
    $display("test_reset done");
  endtask

  task automatic test_best_price();
    do_reset();
    send_buy(8'd30, 8'd1); send_buy(8'd35, 8'd1); send_buy(8'd32, 8'd1);
    send_sell(8'd80, 8'd1); send_sell(8'd75, 8'd1);
    checks++; if (best_bid !== 8'd35) begin errors++; $display("FAIL best_bid_max got=%0d exp=35", best_bid); end
    checks++; if (best_ask !== 8'd75) begin errors++; $display("FAIL best_ask_min got=%0d exp=75", best_ask); end
    checks++; if (bid_count !== 3 || ask_count !== 2) begin errors++; $display("FAIL best_counts got=%0d/%0d exp=3/2", bid_count, ask_count); end
    $display("test_best_price done");
  endtask

  task automatic test_simple_cross();
    do_reset();
    send_buy(8'd100, 8'd5);
    checks++; if (bid_count !== 1 || best_bid !== 8'd100) begin errors++; $display("FAIL cross_buy_visible got=%0d/%0d exp=1/100", bid_count, best_bid); end
    send_sell(8'd90, 8'd5);
    checks++; if (trade_valid !== 0) begin errors++; $display("FAIL cross_eval_cycle valid=%0b exp=0", trade_valid); end
    wait_trade();
    checks++; if (trade_price !== 8'd95 || trade_qty !== 8'd5) begin errors++; $display("FAIL cross_trade got=%0d x %0d exp=95 x 5", trade_price, trade_qty); end
    tick();
    checks++; if (bid_count !== 0 || ask_count !== 0 || trade_valid !== 0) begin errors++; $display("FAIL cross_after got=%0d/%0d/%0b exp=0/0/0", bid_count, ask_count, trade_valid); end
    $display("test_simple_cross done");
  endtask

  task automatic test_partial_fill();
    do_reset();
    send_buy(8'd50, 8'd10);
    send_sell(8'd50, 8'd4);
    wait_trade();
    checks++; if (trade_price !== 8'd50 || trade_qty !== 8'd4) begin errors++; $display("FAIL partial_trade got=%0d x %0d exp=50 x 4", trade_price, trade_qty); end
    tick();
    checks++; if (bid_count !== 1 || ask_count !== 0 || best_bid !== 8'd50) begin errors++; $display("FAIL partial_rest got=%0d/%0d/%0d exp=1/0/50", bid_count, ask_count, best_bid); end
    send_sell(8'd50, 8'd6);
    wait_trade();
    checks++; if (trade_qty !== 8'd6) begin errors++; $display("FAIL partial_remaining_qty got=%0d exp=6", trade_qty); end
    tick();
    checks++; if (bid_count !== 0 || ask_count !== 0) begin errors++; $display("FAIL partial_empty got=%0d/%0d exp=0/0", bid_count, ask_count); end
    $display("test_partial_fill done");
  endtask

  task automatic test_backpressure();
    do_reset();
    trade_ready = 0;
    send_buy(8'd60, 8'd3);
    send_sell(8'd40, 8'd1);
    send_sell(8'd45, 8'd1);
    wait_trade();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (trade_valid !== 1 || trade_price !== 8'd50 || trade_qty !== 8'd1) begin
        errors++; $display("FAIL bp_hold cyc=%0d got=%0b/%0d/%0d exp=1/50/1", i, trade_valid, trade_price, trade_qty);
      end
      tick();
    end
    checks++; if (ask_count !== 2 || bid_count !== 1) begin errors++; $display("FAIL bp_held_counts got=%0d/%0d exp=1/2", bid_count, ask_count); end
    trade_ready = 1;
    tick();
    checks++; if (trade_valid !== 0 || ask_count !== 1) begin errors++; $display("FAIL bp_release got=%0b/%0d exp=0/1", trade_valid, ask_count); end
    wait_trade();
    checks++; if (trade_price !== 8'd52 || trade_qty !== 8'd1) begin errors++; $display("FAIL bp_second got=%0d x %0d exp=52 x 1", trade_price, trade_qty); end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (trade_valid !== 0) begin errors++; $display("FAIL bp_no_third cyc=%0d valid=%0b exp=0", i, trade_valid); end
      tick();
    end
    checks++; if (bid_count !== 1 || ask_count !== 0 || best_bid !== 8'd60) begin errors++; $display("FAIL bp_final got=%0d/%0d/%0d exp=1/0/60", bid_count, ask_count, best_bid); end
    $display("test_backpressure done");
  endtask

  task automatic test_full_priority();
    do_reset();
    for (int i = 0; i < 8; i++) send_buy(8'd70, 8'(i + 1));
    buy_valid = 1; buy_price = 8'd70; buy_qty = 8'd9;
    checks++; if (bid_count !== 8 || buy_ready !== 0) begin errors++; $display("FAIL full_ready got=%0d/%0b exp=8/0", bid_count, buy_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bid_count !== 8 || buy_ready !== 0) begin errors++; $display("FAIL full_hold cyc=%0d got=%0d/%0b exp=8/0", i, bid_count, buy_ready); end
    end
    sell_valid = 1; sell_price = 8'd70; sell_qty = 8'd1;
    checks++; if (sell_ready !== 1) begin errors++; $display("FAIL full_sell_ready got=%0b exp=1", sell_ready); end
    tick();
    sell_valid = 0;
    tick();
    checks++; if (trade_valid !== 1 || trade_price !== 8'd70 || trade_qty !== 8'd1) begin errors++; $display("FAIL full_trade got=%0b/%0d/%0d exp=1/70/1", trade_valid, trade_price, trade_qty); end
    tick();
    checks++; if (bid_count !== 7 || buy_ready !== 1) begin errors++; $display("FAIL full_after got=%0d/%0b exp=7/1", bid_count, buy_ready); end
    tick();
    buy_valid = 0;
    checks++; if (bid_count !== 8) begin errors++; $display("FAIL full_ninth_accepted got=%0d exp=8", bid_count); end
    send_sell(8'd70, 8'd5);
    wait_trade();
    checks++; if (trade_qty !== 8'd2) begin errors++; $display("FAIL prio_first got=%0d exp=2", trade_qty); end
    tick();
    wait_trade();
    checks++; if (trade_qty !== 8'd3) begin errors++; $display("FAIL prio_second got=%0d exp=3", trade_qty); end
    tick();
    checks++; if (bid_count !== 6 || ask_count !== 0) begin errors++; $display("FAIL prio_counts got=%0d/%0d exp=6/0", bid_count, ask_count); end
    $display("test_full_priority done");
  endtask

  task automatic test_boundaries();
    do_reset();
    send_buy(8'hFF, 8'd3);
    send_sell(8'hFF, 8'd3);
    wait_trade();
    checks++; if (trade_price !== 8'hFF || trade_qty !== 8'd3) begin errors++; $display("FAIL bound_ff got=%0h x %0d exp=ff x 3", trade_price, trade_qty); end
    tick();
    buy_valid = 1; buy_price = 8'd10; buy_qty = 8'd0;
    checks++; if (buy_ready !== 1) begin errors++; $display("FAIL zero_qty_ready got=%0b exp=1", buy_ready); end
    tick();
    buy_valid = 0;
    checks++; if (bid_count !== 0 || best_bid !== 8'd0) begin errors++; $display("FAIL zero_qty_discard got=%0d/%0d exp=0/0", bid_count, best_bid); end
    trade_ready = 0;
    send_buy(8'd20, 8'd1);
    send_sell(8'd10, 8'd1);
    wait_trade();
    reset = 1;
    tick();
    checks++; if (trade_valid !== 0 || bid_count !== 0 || ask_count !== 0 || best_ask !== 8'hFF) begin errors++; $display("FAIL reset_mid_trade got=%0b/%0d/%0d/%0h exp=0/0/0/ff", trade_valid, bid_count, ask_count, best_ask); end
    reset = 0;
    trade_ready = 1;
    tick();
    checks++; if (trade_valid !== 0 || trade_qty !== 0) begin errors++; $display("FAIL reset_mid_after got=%0b/%0d exp=0/0", trade_valid, trade_qty); end
    $display("test_boundaries done");
  endtask

  initial begin
    test_reset();
    test_best_price();
    test_simple_cross();
    test_partial_fill();
    test_backpressure();
    test_full_priority();
    test_boundaries();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/order_book_matcher.md
Name: order_book_matcher

Overview:
- Parametrised successor to the 8-entry shift-register matcher.
- Holds a price-time-priority limit order book: up to DEPTH resting orders per side, each with price and quantity.
- Orders enter through valid/ready handshakes. Crossed books are matched one trade at a time through a valid/ready trade output.
- Partially filled orders stay resting with the reduced quantity. Fully filled orders are removed.

Parameters:
- PRICE_W, 8, price width in bits (unsigned).
- QTY_W, 8, quantity width in bits (unsigned).
- DEPTH, 8, resting-order capacity per side (>=2).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; clears book, FSM and all outputs.
- buy_valid  in  1  buy order offered.
- buy_ready  out  1  buy order accepted this cycle when buy_valid is also high.
- buy_price  in  PRICE_W  buy limit price.
- buy_qty  in  QTY_W  buy quantity.
- sell_valid  in  1  sell order offered.
- sell_ready  out  1  sell order accepted this cycle when sell_valid is also high.
- sell_price  in  PRICE_W  sell limit price.
- sell_qty  in  QTY_W  sell quantity.
- trade_valid  out  1  trade record presented.
- trade_ready  in  1  downstream consumes the trade record.
- trade_price  out  PRICE_W  execution price.
- trade_qty  out  QTY_W  executed quantity.
- best_bid  out  PRICE_W  highest resting buy price; 0 when book empty.
- best_ask  out  PRICE_W  lowest resting sell price; all-ones when book empty.
- bid_count  out  clog2(DEPTH+1)  resting buy orders.
- ask_count  out  clog2(DEPTH+1)  resting sell orders.

Behaviour:
- Reset: counts 0, best_bid 0, best_ask all-ones, trade_valid 0, trade_price 0, trade_qty 0, FSM IDLE. A reset asserted mid-trade drops the pending trade, with no handshake.
- Storage per side is an arrival-ordered compacted array:
  - index 0 is the oldest order;
  - a new order is written at index count;
  - removing index k shifts entries k+1..count-1 down by one in the same edge.
- Best price selection:
  - best bid is the maximum price over valid entries; best ask is the minimum.
  - Ties go to the lowest index (oldest order).
  - Selection is combinational from registered storage.
- buy_ready = (state==IDLE) && (bid_count<DEPTH). sell_ready is the same rule on the ask side. Buy and sell may both be accepted in the same cycle.
- Zero-quantity order: handshaken normally, discarded, count unchanged.
- Latency: an order accepted at edge N is visible in best_bid/best_ask and the counts after edge N.
- FSM IDLE:
  - Condition: bid_count>0 and ask_count>0 and best_bid>=best_ask.
  - Action: latch the best bid/ask indices, trade_price and trade_qty.
  - Then: move to TRADE and assert trade_valid from the next cycle.
  - An order accepted on the same IDLE cycle is not considered until the following cycle.
- Trade arithmetic:
  - trade_price = floor((best_bid+best_ask)/2), computed at PRICE_W+1 bits with no overflow.
  - trade_qty = min(bid_qty, ask_qty).
- FSM TRADE:
  - trade_valid=1. Outputs are held stable while trade_ready=0.
  - On trade_valid&&trade_ready, both matched entries have trade_qty subtracted.
  - Any entry reaching 0 is removed; both sides may lose an entry on the same edge.
  - Then return to IDLE, trade_valid=0 next cycle.
- Back-to-back trades are at most one per 2 cycles, because there is one IDLE evaluation cycle between trades.
- Full side: ready low. Orders are never dropped silently; upstream holds valid.

Optional Feature:
- Macro: ORDER_BOOK_STATS_EN.
- Defined: extra outputs trade_count (32-bit) and volume (32-bit).
  - Both increment on each trade handshake, trade_count by 1 and volume by trade_qty.
  - Both saturate at all-ones and are cleared by reset.
- Undefined: the ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package/include matching_pkg holds:
  - FSM state encodings IDLE/TRADE;
  - a localparam function for the count width (clog2(DEPTH+1));
  - empty-book sentinels (bid 0, ask all-ones) as functions of PRICE_W.
- Sub-module book_side, instantiated twice with parameter IS_BID (1 = max search, 0 = min search). It owns storage, insert, subtract/remove-with-compaction, best price/index/qty and count.
- The top level owns the FSM, trade arithmetic, handshakes and the optional stats.

Test Plan:
- Reset: after reset → best_bid=0x00, best_ask=0xFF, counts 0, trade_valid=0, buy_ready=sell_ready=1.
- Simple cross: buy 100x5, then sell 90x5 → one trade price 95 qty 5; both counts return to 0.
- Partial fill: buy 50x10, sell 50x4 → trade 50x4; bid_count=1 with qty 6, ask_count=0.
- Backpressure and multi-trade: buy 60x3, sell 40x1, sell 45x1 with trade_ready=0 for 5 cycles.
  - Trade (50,1) is held stable until trade_ready goes high.
  - The next trade then matches ask 45 at price 52 qty 1.
  - A third trade never occurs because the ask side is empty.
- Full and time priority: 8 buys at 70, then a 9th buy → buy_ready=0 and it is held. A sell 70x1 matches index 0 (oldest), price 70; after the trade buy_ready=1.
- Boundaries: buy 0xFF with sell 0xFF → trade 0xFF (no overflow). A qty-0 order is accepted but not stored. Reset asserted during TRADE → trade_valid=0 next cycle and the book is empty.
